// File: rtl/ps2_keycode_if.sv
// Bundle of PS/2 pin inputs and decoded keyboard outputs for ps2_keycode.
// master drives the keyboard pins and observes results; slave is the decoder.
interface ps2_keycode_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keycode;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        frame_err;

   modport master (output ps2_clk, ps2_data,
                   input  keycode, byte_valid, byte_data, frame_err);
   modport slave  (input  ps2_clk, ps2_data,
                   output keycode, byte_valid, byte_data, frame_err);
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 set-2 receiver and two-slot HID keycode tracker for the game keys.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection of frames.
module ps2_keycode #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic         Clk,
   input logic         Reset,
   ps2_keycode_if.slave bus
);

   localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]  clk_p0, dat_p0;
   logic        clk_p2, fall_p2, bit_p2;
   state_t      state, state_next;
   logic [2:0]  cnt, cnt_next;
   logic [7:0]  shift, shift_next;
   logic [15:0] timer;
   logic        timeout, par_ok, frame_ok, frame_bad;
   logic [15:0] keycode;
   logic [7:0]  byte_data;
   logic        byte_valid, frame_err, ext, brk;
`ifdef PS2_PARITY_CHECK_EN
   logic        par, par_next;
`endif

   function automatic logic [7:0] map_key(input logic [7:0] sc);
      case (sc)
         8'h1D:   map_key = 8'h1A;
         8'h1C:   map_key = 8'h04;
         8'h1B:   map_key = 8'h16;
         8'h23:   map_key = 8'h07;
         8'h29:   map_key = 8'h2C;
         default: map_key = 8'h00;
      endcase
   endfunction

   // A released upper key pulls the lower key up so a lone key stays in [15:8].
   function automatic logic [15:0] update_keys(input logic [15:0] kc,
                                               input logic [7:0] k,
                                               input logic release_key);
      update_keys = kc;
      if (k != 8'h00) begin
         if (!release_key) begin
            if (k != kc[15:8] && k != kc[7:0]) begin
               if (kc[15:8] == 8'h00)     update_keys = {k, kc[7:0]};
               else if (kc[7:0] == 8'h00) update_keys = {kc[15:8], k};
            end
         end else if (kc[7:0] == k) begin
            update_keys = {kc[15:8], 8'h00};
         end else if (kc[15:8] == k) begin
            update_keys = {kc[7:0], 8'h00};
         end
      end
   endfunction

   // Synchronisers idle high so reset release never fakes a falling edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         clk_p0  <= 2'b11;
         dat_p0  <= 2'b11;
         clk_p2  <= 1'b1;
         fall_p2 <= 1'b0;
         bit_p2  <= 1'b1;
      end else begin
         clk_p0  <= {clk_p0[0], bus.ps2_clk};
         dat_p0  <= {dat_p0[0], bus.ps2_data};
         clk_p2  <= clk_p0[1];
         fall_p2 <= clk_p2 & ~clk_p0[1];
         bit_p2  <= dat_p0[1];
      end
   end

   assign timeout = (state != IDLE) && !fall_p2 && (timer == TMO);

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ^{shift, par};
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      shift_next = shift;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_next   = par;
`endif
      if (timeout) begin
         state_next = IDLE;
         frame_bad  = 1'b1;
      end else if (fall_p2) begin
         case (state)
            IDLE: begin
               if (!bit_p2) begin
                  state_next = DATA;
                  cnt_next   = 3'd0;
               end
            end
            DATA: begin
               shift_next = {bit_p2, shift[7:1]};
               cnt_next   = cnt + 3'd1;
               if (cnt == 3'd7) state_next = PARITY;
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_next   = bit_p2;
`endif
               state_next = STOP;
            end
            STOP: begin
               state_next = IDLE;
               if (bit_p2 && par_ok) frame_ok  = 1'b1;
               else                  frame_bad = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
         shift <= 8'h00;
         timer <= 16'd0;
`ifdef PS2_PARITY_CHECK_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         shift <= shift_next;
`ifdef PS2_PARITY_CHECK_EN
         par   <= par_next;
`endif
         if (fall_p2 || timeout) timer <= 16'd0;
         else if (state != IDLE) timer <= timer + 16'd1;
      end
   end

   // Byte decoder: prefix flags and keycode update on the cycle after the stop edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         keycode    <= 16'h0000;
         byte_data  <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         ext        <= 1'b0;
         brk        <= 1'b0;
      end else begin
         byte_valid <= frame_ok;
         frame_err  <= frame_bad;
         if (frame_bad) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
         if (frame_ok) begin
            byte_data <= shift;
            case (shift)
               8'hE0: ext <= 1'b1;
               8'hF0: brk <= 1'b1;
               default: begin
                  ext <= 1'b0;
                  brk <= 1'b0;
                  if (!ext) keycode <= update_keys(keycode, map_key(shift), brk);
               end
            endcase
         end
      end
   end

   assign bus.keycode    = keycode;
   assign bus.byte_data  = byte_data;
   assign bus.byte_valid = byte_valid;
   assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_keycode.sv
// Randomised self-checking bench for ps2_keycode: a held-key list model
// predicts each byte/error event and the keycode, checked every cycle.
module tb_ps2_keycode;
   localparam int TMO = 100;
   localparam int H   = 8;

   logic Clk = 1'b0;
   logic Reset = 1'b1;

   ps2_keycode_if bus();

   ps2_keycode #(.TIMEOUT_CYCLES(TMO)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit          err;
      logic [7:0]  b;
      logic [15:0] kc;
   } ev_t;

   ev_t         q[$];
   ev_t         e;
   logic [7:0]  held[$];
   bit          m_ext, m_brk;
   logic [15:0] cur_kc = 16'h0000;
   int          n_chk = 0, n_fail = 0, n_valid = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] hid(input logic [7:0] s);
      case (s)
         8'h1D:   return 8'h1A;
         8'h1C:   return 8'h04;
         8'h1B:   return 8'h16;
         8'h23:   return 8'h07;
         8'h29:   return 8'h2C;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [15:0] model_kc();
      logic [7:0] a, b;
      a = (held.size() > 0) ? held[0] : 8'h00;
      b = (held.size() > 1) ? held[1] : 8'h00;
      return {a, b};
   endfunction

   // Held keys kept in press order, at most two; keycode is just that list.
   task automatic model_frame(input logic [7:0] b, input bit good);
      ev_t        ev;
      logic [7:0] k;
      int         idx;
      ev.err = !good;
      ev.b   = b;
      if (!good) begin
         m_ext = 0;
         m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         k = hid(b);
         if (!m_ext && k != 8'h00) begin
            idx = -1;
            for (int i = 0; i < held.size(); i++) if (held[i] == k) idx = i;
            if (m_brk) begin
               if (idx >= 0) held.delete(idx);
            end else if (idx < 0 && held.size() < 2) begin
               held.push_back(k);
            end
         end
         m_ext = 0;
         m_brk = 0;
      end
      ev.kc = model_kc();
      q.push_back(ev);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
      logic [10:0] bits;
      logic        p;
      bit          good;
      p    = ~(^b) ^ bad_par;
      bits = {~bad_stop, p, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
      good = !bad_stop && !bad_par;
`else
      good = !bad_stop;
`endif
      for (int i = 0; i < 11; i++) begin
         bus.ps2_data = bits[i];
         cyc(H);
         if (i == 10) model_frame(b, good);
         bus.ps2_clk = 1'b0;
         cyc(H);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
      cyc(40);
   endtask

   task automatic partial(input int nedges);
      for (int i = 0; i < nedges; i++) begin
         bus.ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(1));
         cyc(H);
         bus.ps2_clk = 1'b0;
         cyc(H);
         bus.ps2_clk = 1'b1;
      end
   endtask

   task automatic do_timeout();
      partial(5);
      model_frame(8'h00, 0);
      cyc(TMO + 30);
      bus.ps2_data = 1'b1;
      cyc(10);
   endtask

   always @(negedge Clk) begin
      if (Reset) begin
         cur_kc = 16'h0000;
      end else begin
         chk("valid_err_exclusive", 32'(bus.byte_valid & bus.frame_err), 32'd0);
         if (bus.byte_valid || bus.frame_err) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_event: valid=%b err=%b nothing pending at %0t",
                        bus.byte_valid, bus.frame_err, $time);
            end else begin
               e = q.pop_front();
               chk("event_kind_err", 32'(bus.frame_err), 32'(e.err));
               if (!e.err) chk("byte_data", 32'(bus.byte_data), 32'(e.b));
               cur_kc = e.kc;
               if (bus.byte_valid) n_valid++;
               else n_err++;
            end
         end
         chk("keycode", 32'(bus.keycode), 32'(cur_kc));
      end
   end

   initial begin
      int         v0, e0;
      logic [7:0] pool [8];
      logic [7:0] b;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      m_ext = 0;
      m_brk = 0;
      cyc(3);
      Reset = 1'b0;
      cyc(3);
      chk("reset_keycode", 32'(bus.keycode), 32'h0000);
      chk("reset_byte_data", 32'(bus.byte_data), 32'h00);
      chk("reset_byte_valid", 32'(bus.byte_valid), 32'd0);
      chk("reset_frame_err", 32'(bus.frame_err), 32'd0);

      v0 = n_valid;
      send(8'h1C);
      chk("make_A", 32'(bus.keycode), 32'h0400);
      send(8'hF0); send(8'h1C);
      chk("break_A", 32'(bus.keycode), 32'h0000);
      chk("valid_pulses_3", 32'(n_valid - v0), 32'd3);

      send(8'h1D); send(8'h23);
      chk("two_keys", 32'(bus.keycode), 32'h1A07);
      send(8'hF0); send(8'h1D);
      chk("compaction", 32'(bus.keycode), 32'h0700);
      send(8'hF0); send(8'h23);

      send(8'h1D); send(8'h1D); send(8'h1C); send(8'h29);
      chk("repeat_rollover", 32'(bus.keycode), 32'h1A04);
      send(8'hF0); send(8'h29);
      chk("break_dropped_key", 32'(bus.keycode), 32'h1A04);
      send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1C);
      chk("cleared", 32'(bus.keycode), 32'h0000);

      v0 = n_valid;
      e0 = n_err;
      send(8'h23, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
      chk("parity_err_keycode", 32'(bus.keycode), 32'h0000);
      chk("parity_err_pulse", 32'(n_err - e0), 32'd1);
      chk("parity_err_no_valid", 32'(n_valid - v0), 32'd0);
`else
      chk("parity_ignored_keycode", 32'(bus.keycode), 32'h0700);
      chk("parity_ignored_no_err", 32'(n_err - e0), 32'd0);
`endif
      send(8'hF0); send(8'h23);

      e0 = n_err;
      do_timeout();
      chk("timeout_err", 32'(n_err - e0), 32'd1);
      send(8'h1C);
      chk("after_timeout", 32'(bus.keycode), 32'h0400);
      send(8'hF0); send(8'h1C);

      e0 = n_err;
      send(8'h1C, 0, 1);
      chk("bad_stop_err", 32'(n_err - e0), 32'd1);
      chk("bad_stop_keycode", 32'(bus.keycode), 32'h0000);

      send(8'hE0); send(8'h1D);
      chk("extended_ignored", 32'(bus.keycode), 32'h0000);

      send(8'h1B);
      partial(4);
      Reset = 1'b1;
      #2;
      chk("midframe_reset_keycode", 32'(bus.keycode), 32'h0000);
      chk("midframe_reset_byte_data", 32'(bus.byte_data), 32'h00);
      chk("midframe_reset_valid", 32'(bus.byte_valid), 32'd0);
      chk("midframe_reset_err", 32'(bus.frame_err), 32'd0);
      held.delete();
      q.delete();
      m_ext = 0;
      m_brk = 0;
      bus.ps2_data = 1'b1;
      cyc(3);
      Reset = 1'b0;
      cyc(5);
      send(8'h1C);
      chk("after_reset_frame", 32'(bus.keycode), 32'h0400);

      pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'hE0, 8'hF0, 8'h00};
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(24) == 0) begin
            do_timeout();
         end else begin
            b = pool[$urandom_range(7)];
            if (b == 8'h00) b = 8'($urandom);
            send(b, $urandom_range(9) == 0, $urandom_range(19) == 0);
         end
      end

      cyc(20);
      chk("events_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_keycode.md
# ps2_keycode

Receives a PS/2 keyboard byte stream, decodes scan-code set 2 make/break sequences for the game keys, and maintains the two-slot 16-bit keycode consumed by the player and shooting logic. It sits between the keyboard pins and every block that reads `keycode`. It presents held keys as USB HID usage codes, with a single held key always in the upper byte (for example, A alone reads 16'h0400).

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of `Clk` cycles with no PS/2 clock falling edge after which a partial frame is abandoned.
- `Clk`  in  1: system clock. All state is updated on its rising edge.
- `Reset`  in  1: reset, asynchronous and active-high.
- `ps2_clk`  in  1: raw keyboard clock, asynchronous to `Clk`.
- `ps2_data`  in  1: raw keyboard data, asynchronous to `Clk`.
- `keycode`  out  16: `[15:8]` is the first held key and `[7:0]` is the second held key, as HID codes. 8'h00 means the slot is empty.
- `byte_valid`  out  1: one-cycle pulse for each correctly framed byte.
- `byte_data`  out  8: the last good byte. Held until the next good byte.
- `frame_err`  out  1: one-cycle pulse when a frame is rejected.

## Operation
- **Input synchronisation:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A falling edge is defined as synced `ps2_clk` high in the previous cycle and low in the current cycle. Data is sampled only on that edge.
- **Frame FSM:**
  - IDLE → DATA when the edge samples data = 0 (start bit). If the edge samples data = 1, the FSM stays in IDLE.
  - DATA shifts in 8 bits, LSB first, with a 3-bit counter, then → PARITY.
  - PARITY latches the bit, then → STOP.
  - STOP → IDLE. The frame is accepted only if the stop bit is 1 and the parity check passes. Otherwise `frame_err` pulses and the byte is dropped.
- **Timeout:** a 16-bit counter clears on every falling edge and increments while the FSM is not in IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `frame_err` pulses, and the partial byte is discarded.
- **Byte decoder:**
  - 8'hE0 sets the `ext` flag.
  - 8'hF0 sets the `brk` flag.
  - Any other byte is a key. Both flags clear after any key byte and after any `frame_err`.
  - A key byte with `ext` set is consumed and ignored.
- **Scan-code map** (set 2 → HID):
  - 1D→1A (W)
  - 1C→04 (A)
  - 1B→16 (S)
  - 23→07 (D)
  - 29→2C (Space)
  - All other codes are ignored.
- **Make** (`brk` = 0), mapped code K:
  - If K is already in either slot, no change (typematic repeat).
  - Else if `[15:8]` = 0, write K there.
  - Else if `[7:0]` = 0, write K there.
  - Else drop K (2-key rollover).
- **Break** (`brk` = 1), mapped code K:
  - If K is in `[7:0]`, clear `[7:0]`.
  - If K is in `[15:8]`, the new `[15:8]` is the old `[7:0]` and `[7:0]` is cleared (compaction).
  - If K is in neither slot, no change.

## Timing
- **Reset values:** `keycode` = 16'h0000, `byte_data` = 8'h00, `byte_valid` = 0, `frame_err` = 0. FSM in IDLE, `ext` = `brk` = 0, counters cleared.
- **Reset during a frame:** all state clears immediately (asynchronous); the partial frame is lost.
- **Edge latency:** a PS/2 falling edge on the pin is detected 3 `Clk` cycles later (2 synchroniser stages + edge register).
- **Byte latency:** `byte_valid`, `byte_data`, and the `keycode` update all take effect on the same `Clk` edge, one cycle after the stop-bit edge is detected.
- **Error and valid:** `frame_err` and `byte_valid` are never asserted in the same cycle.
- **Back-to-back frames:** a start-bit edge arriving in the cycle the FSM re-enters IDLE is accepted.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a frame is accepted only if the 8 data bits plus the parity bit have odd total parity. A failure drops the byte and pulses `frame_err`.
  - Undefined: the parity bit is sampled and discarded. Only the stop bit and the timeout can produce `frame_err`.

## Test plan
- **Single make/break:** after reset, send 1C, then F0 1C → `keycode` 16'h0400 after the first byte, 16'h0000 after the break. `byte_valid` pulses 3 times.
- **Two keys and compaction:** send 1A-equivalent W (1D) then D (23) → 16'h1A07. Then send F0 1D → 16'h0700.
- **Repeat and rollover:** send 1D 1D 1C 29 → 16'h1A04. The repeat and the third key are ignored, and F0 29 causes no change.
- **Parity error** (macro defined): send 23 with an even-parity bit → `frame_err` = 1 for one cycle, `keycode` unchanged, `byte_valid` = 0. With the macro undefined, the same stimulus gives `keycode` 16'h0700.
- **Timeout:** stop `ps2_clk` after 4 data bits for `TIMEOUT_CYCLES` cycles → `frame_err` pulse and FSM back in IDLE. A following clean 1C frame gives 16'h0400.
- **Extended and reset mid-frame:** send E0 1D → no change. Assert `Reset` during the DATA state of a 1C frame → all outputs read 0. The next full 1C frame gives 16'h0400.
